// File: rtl/fan_adder_arb.sv
// fan_adder_arb: round-robin arbiter time-sharing one fan_adder between NUM_REQ requesters.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   req_valid/req_ready                 : per-requester handshake (ready is one-hot or zero)
//   req_mode/req_data/req_tag/req_sel   : per-requester job fields, requester r at slice r
//   fan_add_en/fan_bypass_en/fan_in/
//   fan_edge_tag_in/fan_sel             : issue-stage drive of the shared adder
//   fan_out/fan_out_valid/fan_edge_tag_out : combinational adder result
//   rsp_valid/rsp_ready/rsp_id/rsp_data/
//   rsp_out_valid/rsp_edge_tag/rsp_err  : response stage
//   FAN_ARB_FIXED_PRIO_EN               : when defined, lowest index wins and the pointer is removed
module fan_adder_arb #(
   parameter int NUM_REQ = 4,
   parameter int DW_DATA = 8,
   parameter int NUM_IN  = 2,
   parameter int SEL_IN  = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [2*NUM_REQ-1:0]              req_mode,
   input  logic [DW_DATA*NUM_IN*NUM_REQ-1:0] req_data,
   input  logic [2*NUM_IN*NUM_REQ-1:0]       req_tag,
   input  logic [SEL_IN*2*NUM_REQ-1:0]       req_sel,
   output logic                              fan_add_en,
   output logic                              fan_bypass_en,
   output logic [DW_DATA*NUM_IN-1:0]         fan_in,
   output logic [2*NUM_IN-1:0]               fan_edge_tag_in,
   output logic [SEL_IN*2-1:0]               fan_sel,
   input  logic [2*DW_DATA-1:0]              fan_out,
   input  logic [1:0]                        fan_out_valid,
   input  logic [3:0]                        fan_edge_tag_out,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [ID_W-1:0]                   rsp_id,
   output logic [2*DW_DATA-1:0]              rsp_data,
   output logic [1:0]                        rsp_out_valid,
   output logic [3:0]                        rsp_edge_tag,
   output logic                              rsp_err
);
   localparam int DW_JOB = DW_DATA*NUM_IN;
   localparam int TW     = 2*NUM_IN;
   localparam int SW     = SEL_IN*2;
   logic              iss_valid_q, iss_valid_d;
   logic [1:0]        iss_mode_q, iss_mode_d;
   logic [DW_JOB-1:0] iss_data_q, iss_data_d;
   logic [TW-1:0]     iss_tag_q, iss_tag_d;
   logic [SW-1:0]     iss_sel_q, iss_sel_d;
   logic [ID_W-1:0]   iss_id_q, iss_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [2*DW_DATA-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_out_valid_q, rsp_out_valid_d;
   logic [3:0]        rsp_edge_tag_q, rsp_edge_tag_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_adv, iss_adv, accept, gnt_found, iss_err;
   logic [ID_W-1:0]   gnt_id;
`ifndef FAN_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]   ptr_q, ptr_d;
`endif
   assign rsp_adv = !rsp_valid_q || rsp_ready;
   assign iss_adv = !iss_valid_q || rsp_adv;
   // Search order for the winner; the last match in the loop is the highest-priority one.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
`ifdef FAN_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (req_valid[i]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(i);
         end
`else
      for (int i = NUM_REQ; i >= 1; i--)
         if (req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'((int'(ptr_q) + i) % NUM_REQ);
         end
`endif
   end
   // Ready is forced low while reset is asserted so no requester sees a phantom accept.
   always_comb begin
      req_ready = '0;
      if (rst_n && iss_adv && gnt_found) req_ready[gnt_id] = 1'b1;
   end
   assign accept = |req_ready;
   always_comb begin
      iss_valid_d = iss_adv ? accept : iss_valid_q;
      iss_mode_d  = iss_mode_q;
      iss_data_d  = iss_data_q;
      iss_tag_d   = iss_tag_q;
      iss_sel_d   = iss_sel_q;
      iss_id_d    = iss_id_q;
      if (iss_adv) begin
         iss_mode_d = accept ? req_mode[int'(gnt_id)*2 +: 2] : '0;
         iss_data_d = accept ? req_data[int'(gnt_id)*DW_JOB +: DW_JOB] : '0;
         iss_tag_d  = accept ? req_tag[int'(gnt_id)*TW +: TW] : '0;
         iss_sel_d  = accept ? req_sel[int'(gnt_id)*SW +: SW] : '0;
         iss_id_d   = accept ? gnt_id : '0;
      end
   end
`ifndef FAN_ARB_FIXED_PRIO_EN
   assign ptr_d = accept ? gnt_id : ptr_q;
`endif
   // Modes 00 and 11 are accepted but never enable the adder; their response is zeroed and flagged.
   assign iss_err = iss_mode_q[0] == iss_mode_q[1];
   always_comb begin
      rsp_valid_d     = rsp_adv ? iss_valid_q : rsp_valid_q;
      rsp_id_d        = rsp_id_q;
      rsp_data_d      = rsp_data_q;
      rsp_out_valid_d = rsp_out_valid_q;
      rsp_edge_tag_d  = rsp_edge_tag_q;
      rsp_err_d       = rsp_err_q;
      if (rsp_adv && iss_valid_q) begin
         rsp_id_d        = iss_id_q;
         rsp_data_d      = iss_err ? '0 : fan_out;
         rsp_out_valid_d = iss_err ? '0 : fan_out_valid;
         rsp_edge_tag_d  = iss_err ? '0 : fan_edge_tag_out;
         rsp_err_d       = iss_err;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q     <= 1'b0;
         iss_mode_q      <= '0;
         iss_data_q      <= '0;
         iss_tag_q       <= '0;
         iss_sel_q       <= '0;
         iss_id_q        <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_data_q      <= '0;
         rsp_out_valid_q <= '0;
         rsp_edge_tag_q  <= '0;
         rsp_err_q       <= 1'b0;
`ifndef FAN_ARB_FIXED_PRIO_EN
         ptr_q           <= ID_W'(NUM_REQ-1);
`endif
      end else begin
         iss_valid_q     <= iss_valid_d;
         iss_mode_q      <= iss_mode_d;
         iss_data_q      <= iss_data_d;
         iss_tag_q       <= iss_tag_d;
         iss_sel_q       <= iss_sel_d;
         iss_id_q        <= iss_id_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_id_q        <= rsp_id_d;
         rsp_data_q      <= rsp_data_d;
         rsp_out_valid_q <= rsp_out_valid_d;
         rsp_edge_tag_q  <= rsp_edge_tag_d;
         rsp_err_q       <= rsp_err_d;
`ifndef FAN_ARB_FIXED_PRIO_EN
         ptr_q           <= ptr_d;
`endif
      end
   end
   assign fan_add_en      = iss_valid_q && iss_mode_q == 2'b01;
   assign fan_bypass_en   = iss_valid_q && iss_mode_q == 2'b10;
   assign fan_in          = iss_valid_q ? iss_data_q : '0;
   assign fan_edge_tag_in = iss_valid_q ? iss_tag_q : '0;
   assign fan_sel         = iss_valid_q ? iss_sel_q : '0;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_id          = rsp_id_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_out_valid   = rsp_out_valid_q;
   assign rsp_edge_tag    = rsp_edge_tag_q;
   assign rsp_err         = rsp_err_q;
endmodule

// File: doc/fan_adder_arb.md
# fan_adder_arb

Round-robin arbiter that time-shares one `fan_adder` instance between `NUM_REQ` requesters in the unstructured-sparsity reduction network. Each requester offers one reduction job per handshake: operands, edge tags, mux select and mode. The arbiter registers the winning job into an issue stage that drives the shared adder. It captures the adder result into a response stage tagged with the requester ID. Sustained throughput is one job per cycle. Fixed latency is 2 cycles from accept to `rsp_valid`.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..16.
- `DW_DATA`, 8: operand width, matches the `fan_adder` parameter.
- `NUM_IN`, 2: operands per job, matches the `fan_adder` parameter.
- `SEL_IN`, 2: select width per output, matches the `fan_adder` parameter.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester job valid.
- `req_ready` output NUM_REQ: per-requester accept; one-hot or zero.
- `req_mode` input 2*NUM_REQ: per requester {bypass, add}.
- `req_data` input DW_DATA*NUM_IN*NUM_REQ: operands.
- `req_tag` input 2*NUM_IN*NUM_REQ: edge tags.
- `req_sel` input SEL_IN*2*NUM_REQ: reduction-mux select.
- `fan_add_en`, `fan_bypass_en` output 1 each: drive the shared adder.
- `fan_in`, `fan_edge_tag_in`, `fan_sel` output (widths per `fan_adder`): issue-stage operands.
- `fan_out` input 2*DW_DATA; `fan_out_valid` input 2; `fan_edge_tag_out` input 4: combinational adder result.
- `rsp_valid` output 1; `rsp_ready` input 1: response handshake.
- `rsp_id` output ID_W: requester that issued the job.
- `rsp_data` output 2*DW_DATA; `rsp_out_valid` output 2; `rsp_edge_tag` output 4: captured result.
- `rsp_err` output 1: job had an illegal mode.

## Operation
- Pipeline stage 1 (ISS) is the issue register with `iss_valid`. Pipeline stage 2 (RSP) is the response register with `rsp_valid`.
- `rsp_adv` = `!rsp_valid || rsp_ready`.
- `iss_adv` = `!iss_valid || rsp_adv`.
- Grant is evaluated only when `iss_adv`=1.
  - Search starts at `ptr+1` (mod NUM_REQ).
  - The first requester with `req_valid`=1 wins, and only its `req_ready` is asserted.
  - With no valid requester, `req_ready`=0.
- `req_ready` depends on `req_valid` combinationally. A requester must not make `req_valid` depend on `req_ready`.
- On accept:
  - ISS loads the winner's mode, data, tag, sel and ID.
  - `ptr` updates to the winner's ID.
  - `ptr` does not move on cycles without an accept.
- The `fan_*` outputs are driven from ISS.
  - `fan_add_en` = `iss_valid & mode==2'b01`.
  - `fan_bypass_en` = `iss_valid & mode==2'b10`.
  - When ISS is empty, both enables are 0 and data/tag/sel are 0.
- An illegal mode (2'b00 or 2'b11) is still accepted.
  - Both enables are driven 0.
  - RSP captures `rsp_data`=0, `rsp_out_valid`=0, `rsp_edge_tag`=0 and `rsp_err`=1.
- When `iss_valid && rsp_adv`, RSP captures `fan_out`, `fan_out_valid`, `fan_edge_tag_out`, the ID and the error flag. `rsp_valid` is set to 1.
- When `rsp_valid && rsp_ready` and ISS is empty, `rsp_valid` clears.
- While `rsp_valid && !rsp_ready`:
  - All `rsp_*` outputs hold stable.
  - ISS holds, and its `fan_*` outputs hold.
  - No grant is issued.

## Timing
- Values on reset assertion (asynchronous):
  - `iss_valid`=0 and `rsp_valid`=0.
  - `ptr`=NUM_REQ-1, so requester 0 has first priority.
  - All `rsp_*` and `fan_*` outputs are 0.
  - `req_ready`=0.
- Latency: accept in cycle N gives `fan_*` valid in N+1 and `rsp_valid`=1 in N+2.
- Throughput: with `rsp_ready` held at 1, one accept per cycle and back-to-back responses with no bubble.
- Full pipeline (both stages valid, `rsp_ready`=0): no accepts. When `rsp_ready` rises, RSP and ISS advance and a grant occurs in the same cycle.
- Reset asserted mid-operation discards both stages. In-flight jobs are lost and no response is produced.
- A requester that holds `req_valid` is granted within NUM_REQ accepts (no starvation).

## Configuration
- `FAN_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index wins.
  - `ptr` is removed.
  - The starvation bound does not apply.
- Undefined (default): round-robin as described above.

## Test plan
- Reset with all `req_valid`=1 -> first accept is requester 0. Accepts then follow 1,2,3,0 on consecutive cycles, with `rsp_id` 0,1,2,3,0 starting 2 cycles later.
- Requester 2 job with mode 01, data {8'd5, 8'd3}, tags 4'b0101 -> `fan_add_en`=1 for one cycle. The next cycle gives `rsp_data`={8'd8, 8'd8}, `rsp_id`=2, `rsp_err`=0.
- Mode 10 with data {8'hAA, 8'h55} -> `fan_bypass_en`=1. `rsp_data` equals the selected operands unchanged.
- Mode 11 -> both enables stay 0. Response has `rsp_err`=1 and `rsp_data`=0.
- Hold `rsp_ready`=0 for 5 cycles with all requesters valid -> exactly 2 accepts, `rsp_*` outputs stable, then one accept per cycle after release.
- Assert `rst_n`=0 with both stages full -> `rsp_valid` and `fan_add_en` drop immediately. After release the first grant goes to requester 0.
